ram_arbiter: RTL and testbench

- Shares the single-port data RAM (16-bit address, 16-bit data) between two requesters.
- Port 0 is the asca16core data port; port 1 is the loader/debug master, which fills or dumps RAM while the core runs.
- Sits in top between the requesters and i_ram, and drives the RAM control signals ram_cen, ram_wen, ram_addr and ram_data.
- Provides fixed priority with anti-starvation, a per-port bus lock for atomic sequences, and one-cycle read-return tagging.

---
 rtl/asca_ram_arb_pkg.sv | 27 ++
 rtl/ram_arb_prio.sv | 28 ++
 rtl/ram_arbiter.sv | 178 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/asca_ram_arb_pkg.sv
// Shared encodings and default widths for the data-RAM arbiter.
// Holds no logic, so it adds no latency.
// Carries no handshake, so backpressure does not apply.
package asca_ram_arb_pkg;

    localparam int DEF_AW = 16;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_P0   = 2'b01;
    localparam logic [1:0] OWNER_P1   = 2'b10;

    function automatic logic [1:0] owner_of(input arb_state_t s);
        case (s)
            LOCK0:   return OWNER_P0;
            LOCK1:   return OWNER_P1;
            default: return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ram_arb_prio.sv
// Winner select for the two RAM requesters: lock owner only, else port 0 unless port 1 is preferred.
// Latency: purely combinational, with zero cycles.
// Backpressure: the losing port simply sees no win and keeps its request up.
module ram_arb_prio
    import asca_ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] state,
    input  logic       pref_p1,
    output logic [1:0] win
);

    always_comb begin
        win = 2'b00;
        case (state)
            LOCK0: win[0] = req[0];
            LOCK1: win[1] = req[1];
            default: begin
                if (req[0] && !(req[1] && pref_p1)) begin
                    win[0] = 1'b1;
                end else if (req[1]) begin
                    win[1] = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port data RAM. Lock support is always built in; ASCA_RAM_ARB_RR_EN selects round-robin over fixed priority with anti-starvation.
// Latency: grant and RAM drive are combinational; read data returns with rvalid one cycle after the grant.
// Backpressure: a denied port sees gnt=0 and holds its request until granted.
module ram_arbiter
    import asca_ram_arb_pkg::*;
#(
    parameter int AW       = DEF_AW,
    parameter int DW       = DEF_DW,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic          p0_lock,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [DW-1:0] p0_rdata,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic          p1_lock,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [DW-1:0] p1_rdata,
    input  logic [DW-1:0] ram_out,
    output logic          ram_cen,
    output logic          ram_wen,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_data,
    output logic [1:0]    busy_owner
);

    arb_state_t    state_q;
    arb_state_t    state_d;
    logic [1:0]    req;
    logic [1:0]    win;
    logic [1:0]    gnt;
    logic          pref_p1;
    logic          tag_vld_q;
    logic          tag_port_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    assign req = {p1_req, p0_req};

`ifdef ASCA_RAM_ARB_RR_EN
    // Reset value 1 lets port 0 win the first contested cycle.
    logic last_winner_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_winner_q <= 1'b1;
        end else if (|gnt) begin
            last_winner_q <= gnt[1];
        end
    end

    assign pref_p1 = ~last_winner_q;
`else
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic [3:0] starve_cnt_q;

    // Port 1 denials are not counted while port 0 owns a lock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt_q <= 4'd0;
        end else if (!p1_req || gnt[1]) begin
            starve_cnt_q <= 4'd0;
        end else if (state_q != LOCK0 && starve_cnt_q < MAX_WAIT_C) begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
        end
    end

    assign pref_p1 = (starve_cnt_q == MAX_WAIT_C);
`endif

    ram_arb_prio u_prio (
        .req     (req),
        .state   (state_q),
        .pref_p1 (pref_p1),
        .win     (win)
    );

    // Grants are forced low while reset is held, even with requests pending.
    assign gnt    = win & {2{reset_n}};
    assign p0_gnt = gnt[0];
    assign p1_gnt = gnt[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ARB: begin
                if (gnt[0] && p0_lock) begin
                    state_d = LOCK0;
                end else if (gnt[1] && p1_lock) begin
                    state_d = LOCK1;
                end
            end
            LOCK0: begin
                if (gnt[0] && !p0_lock) begin
                    state_d = ARB;
                end
            end
            LOCK1: begin
                if (gnt[1] && !p1_lock) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        ram_cen  = 1'b0;
        ram_wen  = 1'b0;
        ram_addr = '0;
        ram_data = '0;
        if (gnt[0]) begin
            ram_cen  = 1'b1;
            ram_wen  = p0_we;
            ram_addr = p0_addr;
            ram_data = p0_wdata;
        end else if (gnt[1]) begin
            ram_cen  = 1'b1;
            ram_wen  = p1_we;
            ram_addr = p1_addr;
            ram_data = p1_wdata;
        end
    end

    // The tag remembers which port issued the read the RAM is answering this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_vld_q  <= 1'b0;
            tag_port_q <= 1'b0;
        end else begin
            tag_vld_q <= ram_cen && !ram_wen;
            if (ram_cen) begin
                tag_port_q <= gnt[1];
            end
        end
    end

    assign p0_rvalid = tag_vld_q && !tag_port_q;
    assign p1_rvalid = tag_vld_q && tag_port_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            if (p0_rvalid) begin
                rdata0_q <= ram_out;
            end
            if (p1_rvalid) begin
                rdata1_q <= ram_out;
            end
        end
    end

    assign p0_rdata   = p0_rvalid ? ram_out : rdata0_q;
    assign p1_rdata   = p1_rvalid ? ram_out : rdata1_q;
    assign busy_owner = owner_of(state_q);

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter with a behavioural RAM and a per-port read-data scoreboard.
// Latency: expects grants in the request cycle and read data one cycle after a granted read.
// Backpressure: the requesters hold their requests until granted.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        p0_req, p0_we, p0_lock;
    logic [15:0] p0_addr, p0_wdata;
    logic        p0_gnt, p0_rvalid;
    logic [15:0] p0_rdata;
    logic        p1_req, p1_we, p1_lock;
    logic [15:0] p1_addr, p1_wdata;
    logic        p1_gnt, p1_rvalid;
    logic [15:0] p1_rdata;
    logic [15:0] ram_out;
    logic        ram_cen, ram_wen;
    logic [15:0] ram_addr, ram_data;
    logic [1:0]  busy_owner;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q0[$];
    logic [15:0] exp_q1[$];
    logic [15:0] mem [0:65535];

    always #5 clk = ~clk;

    ram_arbiter #(.AW(16), .DW(16), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .p0_req     (p0_req),
        .p0_we      (p0_we),
        .p0_lock    (p0_lock),
        .p0_addr    (p0_addr),
        .p0_wdata   (p0_wdata),
        .p0_gnt     (p0_gnt),
        .p0_rvalid  (p0_rvalid),
        .p0_rdata   (p0_rdata),
        .p1_req     (p1_req),
        .p1_we      (p1_we),
        .p1_lock    (p1_lock),
        .p1_addr    (p1_addr),
        .p1_wdata   (p1_wdata),
        .p1_gnt     (p1_gnt),
        .p1_rvalid  (p1_rvalid),
        .p1_rdata   (p1_rdata),
        .ram_out    (ram_out),
        .ram_cen    (ram_cen),
        .ram_wen    (ram_wen),
        .ram_addr   (ram_addr),
        .ram_data   (ram_data),
        .busy_owner (busy_owner)
    );

    // Single-port RAM: read data appears the cycle after the address is sampled.
    always @(posedge clk) begin
        if (ram_cen) begin
            if (ram_wen) begin
                mem[ram_addr] <= ram_data;
            end else begin
                ram_out <= mem[ram_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        check("gnt_excl", 32'(p0_gnt & p1_gnt), 32'd0);
        if (p0_rvalid) begin
            if (exp_q0.size() == 0) check("p0_unexp_rvalid", 32'(p0_rvalid), 32'd0);
            else                    check("p0_rdata", 32'(p0_rdata), 32'(exp_q0.pop_front()));
        end
        if (p1_rvalid) begin
            if (exp_q1.size() == 0) check("p1_unexp_rvalid", 32'(p1_rvalid), 32'd0);
            else                    check("p1_rdata", 32'(p1_rdata), 32'(exp_q1.pop_front()));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_req = 1'b0; p0_we = 1'b0; p0_lock = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_lock = 1'b0; p1_addr = '0; p1_wdata = '0;
    endtask

    task automatic drive0(input logic we, input logic lock, input logic [15:0] a, input logic [15:0] d);
        p0_req = 1'b1; p0_we = we; p0_lock = lock; p0_addr = a; p0_wdata = d;
    endtask

    task automatic drive1(input logic we, input logic lock, input logic [15:0] a, input logic [15:0] d);
        p1_req = 1'b1; p1_we = we; p1_lock = lock; p1_addr = a; p1_wdata = d;
    endtask

    initial begin
        logic exp1;
        reset_n = 1'b0;
        idle();
        p0_req = 1'b1;
        @(negedge clk);
        check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
        check("rst_ram_cen", 32'(ram_cen), 32'd0);
        check("rst_busy", 32'(busy_owner), 32'd0);
        check("rst_p0_rdata", 32'(p0_rdata), 32'd0);
        check("rst_p1_rdata", 32'(p1_rdata), 32'd0);
        tick();
        reset_n = 1'b1;
        idle();
        tick();

        // Write then read back on port 0.
        drive0(1'b1, 1'b0, 16'h0010, 16'hA5A5);
        @(negedge clk);
        check("wr_p0_gnt", 32'(p0_gnt), 32'd1);
        check("wr_ram_wen", 32'(ram_wen), 32'd1);
        check("wr_ram_addr", 32'(ram_addr), 32'h0010);
        check("wr_ram_data", 32'(ram_data), 32'hA5A5);
        tick();
        drive0(1'b0, 1'b0, 16'h0010, 16'h0000);
        exp_q0.push_back(16'hA5A5);
        @(negedge clk);
        check("rd_p0_gnt", 32'(p0_gnt), 32'd1);
        check("rd_ram_wen", 32'(ram_wen), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("rd_p0_rvalid", 32'(p0_rvalid), 32'd1);
        check("rd_p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("idle_ram_cen", 32'(ram_cen), 32'd0);
        check("idle_ram_addr", 32'(ram_addr), 32'd0);
        tick();

        // Port 1 locked sequence with port 0 contending.
        drive1(1'b1, 1'b1, 16'h0040, 16'hB000);
        @(negedge clk);
        check("lk1_p1_gnt", 32'(p1_gnt), 32'd1);
        check("lk1_busy", 32'(busy_owner), 32'd0);
        tick();
        drive1(1'b1, 1'b1, 16'h0041, 16'hB001);
        drive0(1'b1, 1'b0, 16'h0030, 16'hC0C0);
        @(negedge clk);
        check("lk2_p1_gnt", 32'(p1_gnt), 32'd1);
        check("lk2_p0_gnt", 32'(p0_gnt), 32'd0);
        check("lk2_busy", 32'(busy_owner), 32'd2);
        tick();
        p1_req = 1'b0;
        @(negedge clk);
        check("lk_idle_p0_gnt", 32'(p0_gnt), 32'd0);
        check("lk_idle_busy", 32'(busy_owner), 32'd2);
        tick();
        drive1(1'b1, 1'b0, 16'h0042, 16'hB002);
        @(negedge clk);
        check("lk3_p1_gnt", 32'(p1_gnt), 32'd1);
        check("lk3_p0_gnt", 32'(p0_gnt), 32'd0);
        check("lk3_busy", 32'(busy_owner), 32'd2);
        tick();
        p1_req = 1'b0;
        @(negedge clk);
        check("unlk_p0_gnt", 32'(p0_gnt), 32'd1);
        check("unlk_busy", 32'(busy_owner), 32'd0);
        tick();
        idle();

        // Back-to-back reads from different ports must not cross over.
        drive0(1'b1, 1'b0, 16'h0001, 16'h1111);
        tick();
        drive0(1'b1, 1'b0, 16'h0002, 16'h2222);
        tick();
        drive0(1'b0, 1'b0, 16'h0001, 16'h0000);
        exp_q0.push_back(16'h1111);
        @(negedge clk);
        check("tag_p0_gnt", 32'(p0_gnt), 32'd1);
        tick();
        p0_req = 1'b0;
        drive1(1'b0, 1'b0, 16'h0002, 16'h0000);
        exp_q1.push_back(16'h2222);
        @(negedge clk);
        check("tag_p1_gnt", 32'(p1_gnt), 32'd1);
        check("tag_p0_rvalid", 32'(p0_rvalid), 32'd1);
        check("tag_p1_rvalid_early", 32'(p1_rvalid), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("tag_p1_rvalid", 32'(p1_rvalid), 32'd1);
        check("tag_p0_rvalid_late", 32'(p0_rvalid), 32'd0);
        check("tag_p0_rdata_hold", 32'(p0_rdata), 32'h1111);
        tick();

        // Reset drops a locked port 1 read in flight; no expectation is queued for it.
        drive1(1'b1, 1'b1, 16'h0060, 16'h1234);
        @(negedge clk);
        check("rs_p1_gnt_wr", 32'(p1_gnt), 32'd1);
        tick();
        drive1(1'b0, 1'b1, 16'h0002, 16'h0000);
        @(negedge clk);
        check("rs_p1_gnt_rd", 32'(p1_gnt), 32'd1);
        check("rs_busy_lock", 32'(busy_owner), 32'd2);
        tick();
        reset_n = 1'b0;
        idle();
        drive0(1'b1, 1'b0, 16'h0050, 16'h5050);
        drive1(1'b1, 1'b0, 16'h0051, 16'h5151);
        @(negedge clk);
        check("rs_p1_rvalid", 32'(p1_rvalid), 32'd0);
        check("rs_busy", 32'(busy_owner), 32'd0);
        check("rs_p0_gnt", 32'(p0_gnt), 32'd0);
        check("rs_p1_gnt", 32'(p1_gnt), 32'd0);
        check("rs_ram_cen", 32'(ram_cen), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;

        // Both ports request continuously from a fresh reset.
        for (int i = 0; i < 15; i++) begin
`ifdef ASCA_RAM_ARB_RR_EN
            exp1 = (i % 2) == 1;
`else
            exp1 = (i % 5) == 4;
`endif
            @(negedge clk);
            check($sformatf("arb_p0_c%0d", i), 32'(p0_gnt), 32'(!exp1));
            check($sformatf("arb_p1_c%0d", i), 32'(p1_gnt), 32'(exp1));
            tick();
        end
        idle();
        tick();
        tick();
        @(negedge clk);
        check("q0_left", 32'(exp_q0.size()), 32'd0);
        check("q1_left", 32'(exp_q1.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
